// File: rtl/systolic_mm_engine_if.sv
// Handshake and data bus of the systolic matrix-multiply engine.
// The master side issues jobs, streams operand beats and drains result rows.
// The slave side is the engine itself.
interface systolic_mm_engine_if #(
  parameter int DATA_WIDTH        = 8,
  parameter int ARRAY_SIZE        = 4,
  parameter int K_MAX             = 16,
  parameter int ACCUMULATOR_WIDTH = 2*DATA_WIDTH + $clog2(K_MAX)
);
  logic                                    start;
  logic [$clog2(K_MAX):0]                  k_len;
  logic                                    signed_mode;
  logic                                    in_valid;
  logic                                    in_ready;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0]        a_col;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0]        b_row;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [ARRAY_SIZE*ACCUMULATOR_WIDTH-1:0] out_row;
  logic [$clog2(ARRAY_SIZE)-1:0]           out_idx;
  logic                                    busy;
  logic                                    done;

  modport master (
    output start, k_len, signed_mode, in_valid, a_col, b_row, out_ready,
    input  in_ready, out_valid, out_row, out_idx, busy, done
  );

  modport slave (
    input  start, k_len, signed_mode, in_valid, a_col, b_row, out_ready,
    output in_ready, out_valid, out_row, out_idx, busy, done
  );
endinterface

// File: rtl/systolic_mm_engine.sv
// NxN output-stationary systolic array computing C = A * B.
// Column k of A and row k of B arrive as one beat; the operands are skewed so
// that PE[i][j] sees A[i][k] and B[k][j] together, then the finished rows of C
// are streamed out one per handshake.
module systolic_mm_engine #(
  parameter int DATA_WIDTH        = 8,
  parameter int ARRAY_SIZE        = 4,
  parameter int K_MAX             = 16,
  parameter int ACCUMULATOR_WIDTH = 2*DATA_WIDTH + $clog2(K_MAX)
) (
  input logic                 clk,
  input logic                 rst_n,
  systolic_mm_engine_if.slave bus
);

  localparam int DW = DATA_WIDTH;
  localparam int N  = ARRAY_SIZE;
  localparam int AW = ACCUMULATOR_WIDTH;
  localparam int KW = $clog2(K_MAX) + 1;
  localparam int IW = $clog2(N);
  localparam int FW = $clog2(2*N);
  localparam logic [KW-1:0] K_MAX_V     = KW'(K_MAX);
  localparam logic [FW-1:0] FLUSH_LAST  = FW'(2*N - 2);
  localparam logic [IW-1:0] ROW_LAST    = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [KW-1:0]   k_reg;
  logic            signed_reg;
  logic [KW-1:0]   beat_cnt;
  logic [FW-1:0]   flush_cnt;
  logic [IW-1:0]   row_idx;
  logic            done_q;

  logic [KW-1:0]   k_clamped;
  logic            start_job;
  logic            accept;
  logic            last_beat;
  logic            flush_last;
  logic            row_hs;
  logic            last_row;
  logic            acc_en;

  logic [DW-1:0]   a_skew [N][N];
  logic [DW-1:0]   b_skew [N][N];
  logic [DW-1:0]   a_op   [N][N];
  logic [DW-1:0]   b_op   [N][N];
  logic [DW-1:0]   a_pass [N][N];
  logic [DW-1:0]   b_pass [N][N];
  logic [AW-1:0]   acc    [N][N];
  logic [N*AW-1:0] out_row_w;

  // Full-width product of two operands, sign- or zero-extended to the
  // accumulator width depending on the latched operand mode.
  function automatic logic [AW-1:0] mul_ext(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic          sgn);
    logic signed [2*DW+1:0] ax;
    logic signed [2*DW+1:0] bx;
    logic signed [2*DW+1:0] prod;
    logic signed [2*DW-1:0] prod_trim;
    ax        = (2*DW+2)'(signed'({sgn & a[DW-1], a}));
    bx        = (2*DW+2)'(signed'({sgn & b[DW-1], b}));
    prod      = ax * bx;
    prod_trim = prod[2*DW-1:0];
    if (sgn) mul_ext = AW'(prod_trim);
    else     mul_ext = AW'(unsigned'(prod_trim));
  endfunction

  assign k_clamped  = (bus.k_len > K_MAX_V) ? K_MAX_V : bus.k_len;
  assign start_job  = (state == IDLE) && bus.start;
  assign accept     = (state == LOAD) && bus.in_valid;
  assign last_beat  = accept && (beat_cnt == k_reg - KW'(1));
  assign flush_last = (state == FLUSH) && (flush_cnt == FLUSH_LAST);
  assign row_hs     = (state == DRAIN) && bus.out_ready;
  assign last_row   = row_hs && (row_idx == ROW_LAST);
  assign acc_en     = (state == LOAD) || (state == FLUSH);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: load K beats, flush the skew, drain N rows.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.start) next_state = (k_clamped == '0) ? FLUSH : LOAD;
      LOAD:    if (last_beat) next_state = FLUSH;
      FLUSH:   if (flush_last) next_state = DRAIN;
      DRAIN:   if (last_row) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Job parameters, beat/flush/row counters and the completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg      <= '0;
      signed_reg <= 1'b0;
      beat_cnt   <= '0;
      flush_cnt  <= '0;
      row_idx    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= last_row;
      if (start_job) begin
        k_reg      <= k_clamped;
        signed_reg <= bus.signed_mode;
        beat_cnt   <= '0;
        flush_cnt  <= '0;
        row_idx    <= '0;
      end
      if (accept)           beat_cnt  <= last_beat ? '0 : beat_cnt + KW'(1);
      if (state == FLUSH)   flush_cnt <= flush_last ? '0 : flush_cnt + FW'(1);
      if (row_hs)           row_idx   <= last_row ? '0 : row_idx + IW'(1);
    end
  end

  // Input skew: row i of A and column j of B pass through i (resp. j) extra
  // stages; cycles without an accepted beat push zeros so gaps are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        for (int s = 0; s < N; s++) begin
          a_skew[i][s] <= '0;
          b_skew[i][s] <= '0;
        end
    end else if (start_job) begin
      for (int i = 0; i < N; i++)
        for (int s = 0; s < N; s++) begin
          a_skew[i][s] <= '0;
          b_skew[i][s] <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++) begin
        a_skew[i][0] <= accept ? bus.a_col[i*DW +: DW] : '0;
        b_skew[i][0] <= accept ? bus.b_row[i*DW +: DW] : '0;
        for (int s = 1; s < N; s++) begin
          a_skew[i][s] <= a_skew[i][s-1];
          b_skew[i][s] <= b_skew[i][s-1];
        end
      end
    end
  end

  // Operand routing: edge PEs take the skew outputs, inner PEs take the
  // registered operand of their left / upper neighbour.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_op[i][0] = a_skew[i][i];
      b_op[0][i] = b_skew[i][i];
    end
    for (int i = 0; i < N; i++)
      for (int j = 1; j < N; j++) begin
        a_op[i][j] = a_pass[i][j-1];
        b_op[j][i] = b_pass[j-1][i];
      end
  end

  // PE grid: forward A right and B down, accumulate while the job computes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_pass[i][j] <= '0;
          b_pass[i][j] <= '0;
          acc[i][j]    <= '0;
        end
    end else if (start_job) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_pass[i][j] <= '0;
          b_pass[i][j] <= '0;
          acc[i][j]    <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_pass[i][j] <= a_op[i][j];
          b_pass[i][j] <= b_op[i][j];
          if (acc_en)
            acc[i][j] <= acc[i][j] + mul_ext(a_op[i][j], b_op[i][j], signed_reg);
        end
    end
  end

  // Result row mux; the row is only exposed while it is being offered.
  always_comb begin
    out_row_w = '0;
    if (state == DRAIN)
      for (int j = 0; j < N; j++)
        out_row_w[j*AW +: AW] = acc[row_idx][j];
  end

  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = (state == DRAIN);
  assign bus.out_row   = out_row_w;
  assign bus.out_idx   = row_idx;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine: a 4x4 and a 3x3 instance share one
// stimulus driver selected by 'sel'. Uniform-matrix jobs come from a vector
// table; the 3x3 ordering, gap/stall and mid-job reset cases are hand-written.
module tb_systolic_mm_engine;

  typedef struct {
    string      name;
    bit         s3;
    bit         sgn;
    int         k;
    logic [7:0] a_v;
    logic [7:0] b_v;
    bit         gap;
    int         stall_row;
    int         exp_beats;
    logic [19:0] exp_c;
  } vec_t;

  logic        clk;
  logic        rst_n;
  bit          sel;
  logic        start;
  logic [4:0]  k_len;
  logic        signed_mode;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a_col;
  logic [31:0] b_row;

  logic        o_in_ready, o_out_valid, o_busy, o_done;
  logic [1:0]  o_out_idx;
  logic [79:0] o_out_row;

  logic [7:0]  a_mat [4][16];
  logic [7:0]  b_mat [16][4];
  logic [19:0] res   [4][4];
  logic [19:0] exp_c [4][4];

  int checks = 0;
  int errors = 0;
  int got_beats, got_rows, early_done, ready_err, order_err, stall_err;
  bit timed_out;
  logic done_at_end, valid_after, busy_after, done_after2;

  systolic_mm_engine_if #(.DATA_WIDTH(8), .ARRAY_SIZE(4), .K_MAX(16), .ACCUMULATOR_WIDTH(20)) if4 ();
  systolic_mm_engine_if #(.DATA_WIDTH(8), .ARRAY_SIZE(3), .K_MAX(16), .ACCUMULATOR_WIDTH(20)) if3 ();

  systolic_mm_engine #(.DATA_WIDTH(8), .ARRAY_SIZE(4), .K_MAX(16), .ACCUMULATOR_WIDTH(20)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave)
  );
  systolic_mm_engine #(.DATA_WIDTH(8), .ARRAY_SIZE(3), .K_MAX(16), .ACCUMULATOR_WIDTH(20)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave)
  );

  assign if4.start       = start & ~sel;
  assign if4.k_len       = k_len;
  assign if4.signed_mode = signed_mode;
  assign if4.in_valid    = in_valid & ~sel;
  assign if4.a_col       = a_col;
  assign if4.b_row       = b_row;
  assign if4.out_ready   = out_ready & ~sel;
  assign if3.start       = start & sel;
  assign if3.k_len       = k_len;
  assign if3.signed_mode = signed_mode;
  assign if3.in_valid    = in_valid & sel;
  assign if3.a_col       = a_col[23:0];
  assign if3.b_row       = b_row[23:0];
  assign if3.out_ready   = out_ready & sel;

  assign o_in_ready  = sel ? if3.in_ready  : if4.in_ready;
  assign o_out_valid = sel ? if3.out_valid : if4.out_valid;
  assign o_busy      = sel ? if3.busy      : if4.busy;
  assign o_done      = sel ? if3.done      : if4.done;
  assign o_out_idx   = sel ? if3.out_idx   : if4.out_idx;
  assign o_out_row   = sel ? {20'd0, if3.out_row} : if4.out_row;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pack_a(input int bi);
    logic [31:0] v;
    v = '0;
    if (bi < 16) for (int i = 0; i < 4; i++) v[i*8 +: 8] = a_mat[i][bi];
    return v;
  endfunction

  function automatic logic [31:0] pack_b(input int bi);
    logic [31:0] v;
    v = '0;
    if (bi < 16) for (int j = 0; j < 4; j++) v[j*8 +: 8] = b_mat[bi][j];
    return v;
  endfunction

  task automatic check_output(input string name, input logic [79:0] act, input logic [79:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic fill_uniform(input logic [7:0] av, input logic [7:0] bv, input logic [19:0] cv);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 16; k++) begin
        a_mat[i][k] = av;
        b_mat[k][i] = bv;
      end
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) exp_c[r][j] = cv;
  endtask

  task automatic fill_3x3_a();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 16; k++) begin
        a_mat[i][k] = (i < 3 && k < 3) ? 8'(3*i + k + 1) : 8'd0;
        b_mat[k][i] = 8'd0;
      end
  endtask

  // Runs one job on the selected instance: start (with junk in_valid on the
  // start cycle), K beats with optional gaps, then drains rows with an
  // optional 10-cycle out_ready stall on one row.
  task automatic apply_stimulus(input bit s3, input bit sgn, input int k, input bit gap, input int stall_row);
    int n, bi, cyc, stall_left, exp_idx;
    bit tog, stalled, last_hs;
    logic [79:0] snap_row;
    logic [1:0]  snap_idx;
    n = s3 ? 3 : 4;
    bi = 0; cyc = 0; stall_left = 0; exp_idx = 0;
    tog = 0; stalled = 0; last_hs = 0;
    snap_row = '0; snap_idx = '0;
    got_beats = 0; got_rows = 0; early_done = 0; ready_err = 0; order_err = 0; stall_err = 0;
    timed_out = 0;
    for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) res[r][j] = '0;
    sel = s3;
    @(negedge clk);
    start = 1'b1; k_len = 5'(k); signed_mode = sgn; in_valid = 1'b1;
    a_col = '1; b_row = '1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!last_hs && cyc < 1000) begin
      if (o_in_ready && (!o_busy || o_out_valid)) ready_err++;
      if (o_done) early_done++;
      if (o_in_ready && (!gap || tog)) begin
        in_valid = 1'b1; a_col = pack_a(bi); b_row = pack_b(bi); bi++;
      end else begin
        in_valid = !o_in_ready; a_col = '1; b_row = '1;
      end
      tog = !tog;
      out_ready = 1'b0;
      if (o_out_valid) begin
        if (int'(o_out_idx) != exp_idx) order_err++;
        if (stall_left > 0) begin
          if (o_out_row !== snap_row || o_out_idx !== snap_idx) stall_err++;
          stall_left--;
        end else if (exp_idx == stall_row && !stalled) begin
          stalled = 1; stall_left = 9; snap_row = o_out_row; snap_idx = o_out_idx;
        end else begin
          out_ready = 1'b1;
          if (exp_idx < 4) for (int j = 0; j < n; j++) res[exp_idx][j] = o_out_row[j*20 +: 20];
          got_rows++; exp_idx++;
          if (exp_idx == n) last_hs = 1;
        end
      end
      cyc++;
      @(negedge clk);
    end
    got_beats = bi;
    in_valid = 1'b0; out_ready = 1'b0;
    if (!last_hs) timed_out = 1;
    done_at_end = o_done; valid_after = o_out_valid; busy_after = o_busy;
    @(negedge clk);
    done_after2 = o_done;
  endtask

  task automatic check_job(input string name, input int n, input int exp_beats, input bit with_stall);
    logic [79:0] act, expv;
    check_output({name, " timeout"}, 80'(timed_out), 80'd0);
    check_output({name, " beats"}, 80'(got_beats), 80'(exp_beats));
    for (int r = 0; r < n; r++) begin
      act = '0; expv = '0;
      for (int j = 0; j < n; j++) begin
        act[j*20 +: 20]  = res[r][j];
        expv[j*20 +: 20] = exp_c[r][j];
      end
      check_output($sformatf("%s row%0d", name, r), act, expv);
    end
    check_output({name, " in_ready_outside_load"}, 80'(ready_err), 80'd0);
    check_output({name, " row_order"}, 80'(order_err), 80'd0);
    check_output({name, " early_done"}, 80'(early_done), 80'd0);
    check_output({name, " done_pulse"}, 80'(done_at_end), 80'd1);
    check_output({name, " valid_dropped"}, 80'(valid_after), 80'd0);
    check_output({name, " idle_after"}, 80'(busy_after), 80'd0);
    check_output({name, " done_one_cycle"}, 80'(done_after2), 80'd0);
    if (with_stall) check_output({name, " stall_stable"}, 80'(stall_err), 80'd0);
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, " in_ready"}, 80'(o_in_ready), 80'd0);
    check_output({name, " out_valid"}, 80'(o_out_valid), 80'd0);
    check_output({name, " busy"}, 80'(o_busy), 80'd0);
    check_output({name, " done"}, 80'(o_done), 80'd0);
    check_output({name, " out_idx"}, 80'(o_out_idx), 80'd0);
    check_output({name, " out_row"}, o_out_row, 80'd0);
  endtask

  initial begin
    vec_t vecs [11];
    int   rst_done;
    vecs[0]  = '{"u255_k16",    0, 0, 16, 8'hFF, 8'hFF, 0, -1, 16, 20'd1040400};
    vecs[1]  = '{"s255_k16",    0, 1, 16, 8'hFF, 8'hFF, 0, -1, 16, 20'd16};
    vecs[2]  = '{"sFFx02_k4",   0, 1, 4,  8'hFF, 8'h02, 0, -1, 4,  20'hFFFF8};
    vecs[3]  = '{"k5_gapless",  0, 0, 5,  8'h03, 8'h07, 0, -1, 5,  20'd105};
    vecs[4]  = '{"k5_gap",      0, 0, 5,  8'h03, 8'h07, 1, -1, 5,  20'd105};
    vecs[5]  = '{"smin_k1",     0, 1, 1,  8'h80, 8'h80, 0, -1, 1,  20'd16384};
    vecs[6]  = '{"sminmax_k16", 0, 1, 16, 8'h80, 8'h7F, 0, -1, 16, 20'hC0800};
    vecs[7]  = '{"clamp_k20",   0, 0, 20, 8'h01, 8'h01, 0, 2,  16, 20'd16};
    vecs[8]  = '{"k0",          0, 0, 0,  8'h55, 8'h55, 0, -1, 0,  20'd0};
    vecs[9]  = '{"n3_u_k3",     1, 0, 3,  8'h0A, 8'h0B, 0, -1, 3,  20'd330};
    vecs[10] = '{"u80x01_k2",   0, 0, 2,  8'h80, 8'h01, 0, -1, 2,  20'd256};

    rst_n = 1'b0; sel = 0; start = 0; k_len = '0; signed_mode = 0;
    in_valid = 0; out_ready = 0; a_col = '0; b_row = '0;
    repeat (3) @(negedge clk);
    sel = 0; check_all_zero("reset4");
    sel = 1; #1 check_all_zero("reset3");
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      fill_uniform(vecs[v].a_v, vecs[v].b_v, vecs[v].exp_c);
      apply_stimulus(vecs[v].s3, vecs[v].sgn, vecs[v].k, vecs[v].gap, vecs[v].stall_row);
      check_job(vecs[v].name, vecs[v].s3 ? 3 : 4, vecs[v].exp_beats, vecs[v].stall_row >= 0);
    end

    fill_3x3_a();
    for (int k = 0; k < 3; k++) b_mat[k][k] = 8'd1;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) exp_c[r][j] = (r < 3 && j < 3) ? 20'(3*r + j + 1) : 20'd0;
    apply_stimulus(1, 0, 3, 0, -1);
    check_job("n3_identity", 3, 3, 0);

    fill_3x3_a();
    b_mat[0][0] = 8'd1; b_mat[1][2] = 8'd1; b_mat[2][1] = 8'd1;
    exp_c[0][0] = 20'd1; exp_c[0][1] = 20'd3; exp_c[0][2] = 20'd2;
    exp_c[1][0] = 20'd4; exp_c[1][1] = 20'd6; exp_c[1][2] = 20'd5;
    exp_c[2][0] = 20'd7; exp_c[2][1] = 20'd9; exp_c[2][2] = 20'd8;
    apply_stimulus(1, 0, 3, 1, 1);
    check_job("n3_perm_gap_stall", 3, 3, 1);

    sel = 1;
    fill_3x3_a();
    for (int k = 0; k < 3; k++) b_mat[k][k] = 8'd1;
    @(negedge clk);
    start = 1'b1; k_len = 5'd3; signed_mode = 0; in_valid = 0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; a_col = pack_a(0); b_row = pack_b(0);
    @(negedge clk);
    a_col = pack_a(1); b_row = pack_b(1);
    check_output("midload busy", 80'(o_busy), 80'd1);
    rst_n = 1'b0;
    #1 check_all_zero("midload_reset");
    in_valid = 1'b0;
    rst_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_done) rst_done++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (o_done) rst_done++;
    end
    check_output("midload no_done", 80'(rst_done), 80'd0);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) exp_c[r][j] = (r < 3 && j < 3) ? 20'(3*r + j + 1) : 20'd0;
    apply_stimulus(1, 0, 3, 0, -1);
    check_job("after_reset_identity", 3, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_mm_engine.md
SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width.
REQ-002 SHALL have parameter ARRAY_SIZE, default 4, PE grid dimension N (NxN).
REQ-003 SHALL have parameter K_MAX, default 16, maximum inner dimension.
REQ-004 SHALL have parameter ACCUMULATOR_WIDTH, default 2*DATA_WIDTH+$clog2(K_MAX), per-PE accumulator width.
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  job request, sampled only in IDLE.
REQ-008 SHALL have port k_len  input  $clog2(K_MAX)+1  inner dimension K, latched at start.
REQ-009 SHALL have port signed_mode  input  1  1 = two's-complement operands, latched at start.
REQ-010 SHALL have port in_valid  input  1  input beat valid.
REQ-011 SHALL have port in_ready  output  1  engine accepts a beat.
REQ-012 SHALL have port a_col  input  N*DATA_WIDTH  column k of A; A[i][k] at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port b_row  input  N*DATA_WIDTH  row k of B; B[k][j] at bits [j*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port out_valid  output  1  result row valid.
REQ-015 SHALL have port out_ready  input  1  sink accepts a result row.
REQ-016 SHALL have port out_row  output  N*ACCUMULATOR_WIDTH  row out_idx of C; C[r][j] at bits [j*ACCUMULATOR_WIDTH +: ACCUMULATOR_WIDTH].
REQ-017 SHALL have port out_idx  output  $clog2(N)  row index of out_row.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.
REQ-019 SHALL have port done  output  1  one-cycle pulse at job completion.

Function
REQ-020 SHALL implement FSM IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE.
REQ-021 IDLE: start=1 SHALL latch k_len (clamped to K_MAX) and signed_mode, clear all accumulators, and go to LOAD (FLUSH if k_len==0).
REQ-022 in_ready SHALL equal (state==LOAD); beats are accepted only on in_valid&&in_ready; in_valid during IDLE, including the start cycle, is ignored.
REQ-023 LOAD SHALL count accepted beats and go to FLUSH on the edge accepting beat K-1.
REQ-024 Internal skew SHALL delay A row i by i cycles and B column j by j cycles; PE[i][j] SHALL accumulate the operands of a beat accepted at edge t on edge t+i+j+1.
REQ-025 Any non-accepting LOAD cycle SHALL inject zero operands into row 0/column 0, so gaps in in_valid leave results unchanged.
REQ-026 FLUSH SHALL inject zeros for exactly 2*N-1 cycles, then enter DRAIN.
REQ-027 PE SHALL pass A right and B down one register per cycle and add the full 2*DATA_WIDTH product, sign-extended when signed_mode=1 and zero-extended otherwise, into the accumulator.
REQ-028 Accumulator SHALL wrap modulo 2^ACCUMULATOR_WIDTH.
REQ-029 DRAIN SHALL assert out_valid with out_idx=0 on entry and advance out_idx on each out_valid&&out_ready.
REQ-030 out_row/out_idx SHALL hold stable while out_valid&&!out_ready.
REQ-031 On handshake of row N-1: out_valid SHALL drop, done SHALL pulse the next cycle, and the state SHALL return to IDLE.
REQ-032 start while busy SHALL be ignored.
REQ-033 in_valid asserted outside LOAD SHALL have no effect.

Reset
REQ-034 rst_n=0 SHALL asynchronously force IDLE, clear accumulators, skew registers and counters, and drive in_ready, out_valid, out_row, out_idx, busy, done to 0.
REQ-035 Reset asserted mid-job SHALL abort the job with no done pulse; the first job after reset SHALL compute correctly.

Verification
REQ-036 N=3, K=3, A=[[1,2,3],[4,5,6],[7,8,9]], B=identity -> rows [1,2,3],[4,5,6],[7,8,9]; done one cycle after row-2 handshake.
REQ-037 N=4, K=16, all A=B=255, signed_mode=0 -> every C=1040400; same data with signed_mode=1 (-1*-1) -> every C=16.
REQ-038 N=4, K=4, A=0xFF, B=2, signed_mode=1 -> every C=-8 in ACCUMULATOR_WIDTH two's complement.
REQ-039 K=5 with in_valid toggled every cycle -> C identical to the gapless run; in_ready high only in LOAD.
REQ-040 out_ready held low 10 cycles mid-DRAIN -> out_row/out_idx stable, no row dropped or duplicated.
REQ-041 k_len=0 -> in_ready never high, N all-zero rows out. Reset pulse mid-LOAD -> all outputs 0 immediately, no done; the next job matches the REQ-036 result.
